// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, funct
// codes, ALU control codes and the bundle of registered datapath controls.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IARITH,
    CLS_MEM,
    CLS_BEQ,
    CLS_J,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       ext_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c           = '0;
    c.alu_src_b = SRC_B_REG;
    c.pc_src    = PC_SRC_ALU;
    c.alu_ctrl  = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// Opcode/funct decode: instruction class, ALU operation for R-type and
// I-type execution, and the immediate extender mode.
module alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output op_class_t  op_class,
  output logic [3:0] r_alu_ctrl,
  output logic       funct_ok,
  output logic [3:0] i_alu_ctrl,
  output logic       i_ext_op
);

  always_comb begin
    op_class   = CLS_ILLEGAL;
    i_alu_ctrl = ALU_ADD;
    i_ext_op   = 1'b1;
    case (op)
      OP_RTYPE: op_class = CLS_R;
      OP_ADDIU: op_class = CLS_IARITH;
      OP_ANDI: begin
        op_class   = CLS_IARITH;
        i_alu_ctrl = ALU_AND;
        i_ext_op   = 1'b0;
      end
      OP_ORI: begin
        op_class   = CLS_IARITH;
        i_alu_ctrl = ALU_OR;
        i_ext_op   = 1'b0;
      end
      OP_LUI: begin
        op_class   = CLS_IARITH;
        i_alu_ctrl = ALU_LUI;
        i_ext_op   = 1'b0;
      end
      OP_LW, OP_SW: op_class = CLS_MEM;
      OP_BEQ: begin
        op_class   = CLS_BEQ;
        i_alu_ctrl = ALU_SUB;
      end
      OP_J: op_class = CLS_J;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    funct_ok   = 1'b1;
    r_alu_ctrl = ALU_ADD;
    case (funct)
      FUNCT_ADDU: r_alu_ctrl = ALU_ADD;
      FUNCT_SUBU: r_alu_ctrl = ALU_SUB;
      FUNCT_AND:  r_alu_ctrl = ALU_AND;
      FUNCT_OR:   r_alu_ctrl = ALU_OR;
      FUNCT_SLT:  r_alu_ctrl = ALU_SLT;
      default:    funct_ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with registered Moore outputs.
// Define MEM_WAIT_EN to stall FETCH/MEM_RD/MEM_WR until mem_ready.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ILLEGAL_HALT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ext_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctrl,
  output logic [3:0] state
);

  localparam state_t ILLEGAL_TARGET = (ILLEGAL_HALT != 0) ? HALT : FETCH;

  op_class_t  op_class;
  logic [3:0] r_alu_ctrl;
  logic [3:0] i_alu_ctrl;
  logic       funct_ok;
  logic       i_ext_op;

  state_t     state_q;
  state_t     state_next;
  logic       started;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_next;
  logic       illegal_q;
  logic       illegal_next;
  logic       mem_done;
  logic       xfer_ok;

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
  // IR/PC must only load on the cycle the fetch actually completes.
  assign xfer_ok  = (state_q != FETCH) || mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
  assign xfer_ok          = 1'b1;
`endif

  alu_dec u_alu_dec (
    .op         (op),
    .funct      (funct),
    .op_class   (op_class),
    .r_alu_ctrl (r_alu_ctrl),
    .funct_ok   (funct_ok),
    .i_alu_ctrl (i_alu_ctrl),
    .i_ext_op   (i_ext_op)
  );

  function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] r_alu,
                                     input logic [3:0] i_alu, input logic i_ext);
    ctrl_t c;
    c = ctrl_idle();
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
        c.pc_src    = PC_SRC_ALU;
      end
      DECODE: begin
        c.ext_op    = 1'b1;
        c.alu_src_b = SRC_B_IMM_SH2;
      end
      EXEC_R: c.alu_ctrl = r_alu;
      EXEC_I: begin
        c.alu_src_b = SRC_B_IMM;
        c.alu_ctrl  = i_alu;
        c.ext_op    = i_ext;
      end
      MEM_ADDR: begin
        c.alu_src_b = SRC_B_IMM;
        c.ext_op    = 1'b1;
      end
      MEM_RD: c.mem_read  = 1'b1;
      MEM_WR: c.mem_write = 1'b1;
      WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      WB_I: c.reg_write = 1'b1;
      WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      // pc_write here is driven directly from the live zero flag.
      BRANCH: begin
        c.ext_op   = 1'b1;
        c.alu_ctrl = ALU_SUB;
        c.pc_src   = PC_SRC_BRANCH;
      end
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_SRC_JUMP;
      end
      default: c = ctrl_idle();
    endcase
    return c;
  endfunction

  always_comb begin
    state_next   = state_q;
    illegal_next = 1'b0;
    if (!started) begin
      // First edge out of reset runs FETCH rather than leaving it.
      state_next = FETCH;
    end else begin
      case (state_q)
        FETCH: if (mem_done) state_next = DECODE;
        DECODE: begin
          case (op_class)
            CLS_R:      state_next = EXEC_R;
            CLS_IARITH: state_next = EXEC_I;
            CLS_MEM:    state_next = MEM_ADDR;
            CLS_BEQ:    state_next = BRANCH;
            CLS_J:      state_next = JUMP;
            default: begin
              state_next   = ILLEGAL_TARGET;
              illegal_next = 1'b1;
            end
          endcase
        end
        EXEC_R: begin
          if (funct_ok) begin
            state_next = WB_R;
          end else begin
            state_next   = ILLEGAL_TARGET;
            illegal_next = 1'b1;
          end
        end
        EXEC_I:   state_next = WB_I;
        MEM_ADDR: state_next = (op == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_done) state_next = WB_MEM;
        MEM_WR:   if (mem_done) state_next = FETCH;
        WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_next = FETCH;
        HALT:     state_next = HALT;
        default:  state_next = FETCH;
      endcase
    end
    ctrl_next = ctrl_for(state_next, r_alu_ctrl, i_alu_ctrl, i_ext_op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      started   <= 1'b0;
      ctrl_q    <= ctrl_idle();
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      started   <= 1'b1;
      ctrl_q    <= ctrl_next;
      illegal_q <= illegal_next;
    end
  end

  assign pc_write   = (ctrl_q.pc_write && xfer_ok) || ((state_q == BRANCH) && zero);
  assign ir_write   = ctrl_q.ir_write && xfer_ok;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign ext_op     = ctrl_q.ext_op;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_src     = ctrl_q.pc_src;
  assign alu_ctrl   = ctrl_q.alu_ctrl;
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter ILLEGAL_HALT, default 0: 1 = illegal opcode enters HALT until reset; 0 = illegal opcode returns to FETCH.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have these ports:
- op, input, 6, instr[31:26] from the IR.
- funct, input, 6, instr[5:0].
- zero, input, 1, ALU zero flag.
- mem_ready, input, 1, memory completion.
REQ-005 The block SHALL have these 1-bit outputs:
- pc_write, ir_write, reg_write, mem_read, mem_write: datapath write/read enables.
- ext_op: extender mode; 1 = sign, 0 = zero.
- reg_dst: 1 = rd, 0 = rt.
- mem_to_reg: 1 = memory data, 0 = ALU result.
- illegal: one-cycle pulse.
REQ-006 The block SHALL have these multi-bit outputs:
- alu_src_b, output, 2: 00 = reg B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- pc_src, output, 2: 00 = ALU, 01 = branch target register, 10 = jump target.
- alu_ctrl, output, 4: ALU operation.
- state, output, 4: current state, for debug.

Function
REQ-007 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP and HALT.
REQ-008 Supported opcodes SHALL be:
- R-type 000000, with funct addu/subu/and/or/slt.
- addiu 001001, andi 001100, ori 001101, lui 001111.
- lw 100011, sw 101011.
- beq 000100, j 000010.
REQ-009 FETCH SHALL assert mem_read, ir_write, pc_write, alu_src_b=01, alu_ctrl=ADD and pc_src=00, then go to DECODE.
REQ-010 DECODE SHALL set ext_op=1, alu_src_b=11 and alu_ctrl=ADD (branch target), then dispatch:
- R → EXEC_R
- I-arith → EXEC_I
- lw/sw → MEM_ADDR
- beq → BRANCH
- j → JUMP
- other → illegal pulse, then FETCH or HALT per ILLEGAL_HALT.
REQ-011 ext_op SHALL be 0 in EXEC_I for andi/ori and 1 for addiu/lw/sw/beq; lui SHALL use alu_ctrl=LUI with ext_op=0.
REQ-012 Unsupported funct in EXEC_R SHALL be handled as an illegal opcode; no register write occurs.
REQ-013 EXEC_R → WB_R (reg_write=1, reg_dst=1, mem_to_reg=0); EXEC_I → WB_I (reg_write=1, reg_dst=0, mem_to_reg=0).
REQ-014 MEM_ADDR SHALL go to MEM_RD for lw and MEM_WR for sw; MEM_RD → WB_MEM (reg_write=1, reg_dst=0, mem_to_reg=1); MEM_WR → FETCH.
REQ-015 BRANCH SHALL set alu_ctrl=SUB and pc_src=01 with pc_write=zero; JUMP SHALL set pc_src=10 and pc_write=1; both SHALL return to FETCH.
REQ-016 All enables SHALL be decoded from the registered state only (Moore), except BRANCH pc_write, and SHALL default to 0 in every state not listed.
REQ-017 Cycle counts SHALL be:
- R-type and I-type: 4.
- lw: 5.
- sw: 4.
- beq: 3.
- j: 3.
These counts exclude memory waits.
REQ-018 HALT SHALL hold all enables at 0 and ignore all inputs until reset.

Reset
REQ-019 rst_n low SHALL immediately force state=FETCH, all enables=0, alu_src_b=00, pc_src=00, alu_ctrl=ADD, ext_op=0 and illegal=0, including mid-instruction.
REQ-020 The first rising edge after rst_n deasserts SHALL execute FETCH, asserting its outputs in that cycle.

Configuration
REQ-021 With MEM_WAIT_EN defined, FETCH, MEM_RD and MEM_WR SHALL hold their outputs and remain in state until mem_ready=1; ir_write/pc_write and reg_write SHALL fire only on the completing cycle.
REQ-022 Without MEM_WAIT_EN, mem_ready SHALL be ignored and every memory state SHALL last exactly one cycle.

Structure
REQ-023 State encodings, opcode/funct constants and alu_ctrl codes (ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111, LUI=1000) SHALL live in shared package mips_ctrl_pkg.
REQ-024 The ALU-control decode (funct/opcode → alu_ctrl, ext_op) SHALL be sub-module alu_dec; the FSM SHALL remain in multicycle_ctrl.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset, then op=000000, funct=100001 → states FETCH,DECODE,EXEC_R,WB_R; reg_write=1 and reg_dst=1 in cycle 4.
- op=001100 (andi) → ext_op=0 in EXEC_I; op=001001 (addiu) → ext_op=1.
- op=000100 with zero=1 → pc_write=1 and pc_src=01 in cycle 3; with zero=0 → pc_write=0.
- MEM_WAIT_EN defined, lw, mem_ready low 3 cycles in MEM_RD → state held 4 cycles, WB_MEM follows, reg_write asserted once.
- op=111111 with ILLEGAL_HALT=0 → one illegal pulse, then FETCH; with ILLEGAL_HALT=1 → HALT persists 20 cycles, with all enables 0.
- rst_n pulsed low during MEM_ADDR → state=FETCH asynchronously, with no mem_write.
